// File: rtl/rpn_converter.sv
// Infix-to-postfix (RPN) converter for ASCII character streams: shunting-yard
// with an internal operator stack, a single output register and sticky error recovery.
module rpn_converter #(
    parameter int         DATA_W      = 8,
    parameter int         STACK_DEPTH = 16,
    parameter bit         EMIT_SEP    = 1'b1,
    parameter logic [7:0] SEP_CHAR    = 8'h20
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               IN_STB,
    input  logic [DATA_W-1:0]                  IN_CHAR,
    output logic                               IN_RDY,
    output logic                               OUT_STB,
    output logic [DATA_W-1:0]                  OUT_CHAR,
    input  logic                               OUT_ACK,
    output logic                               ERR,
    output logic                               DONE,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   STK_LVL
);

    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int IW = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {S_IN, S_DISP, S_POP, S_CLOSE, S_FLUSH, S_ERR} state_t;

    function automatic logic [1:0] prec(input logic [7:0] c);
        case (c)
            "*", "/": prec = 2'd2;
            "+", "-": prec = 2'd1;
            default:  prec = 2'd0;
        endcase
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        is_op = (c == "+") || (c == "-") || (c == "*") || (c == "/");
    endfunction

    state_t        state_q, state_d;
    logic [LW-1:0] sp_q;
    logic [7:0]    stack_mem [STACK_DEPTH];
    logic [7:0]    held_q, held_d;
    logic          in_num_q, in_num_d;
    logic          err_q, done_q;
    logic          out_stb_q, out_eq_q;
    logic [DATA_W-1:0] out_char_q;

    logic          out_free, stk_empty, stk_full, accept, legal;
    logic [LW-1:0] sp_m1;
    logic [7:0]    top, code, ch;
    logic          disp, push, pop, clr_stack, load, load_eq;
    logic [7:0]    push_data, load_data;

    assign sp_m1     = sp_q - LW'(1);
    assign top       = stack_mem[sp_m1[IW-1:0]];
    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == LW'(STACK_DEPTH));
    assign out_free  = !out_stb_q || OUT_ACK;
    assign IN_RDY    = ((state_q == S_IN) || (state_q == S_ERR)) && out_free;
    assign accept    = IN_STB && IN_RDY;

    // Codes with any upper bit set map to 8'h00, which falls through as illegal.
    assign legal     = (IN_CHAR == DATA_W'(IN_CHAR[7:0]));
    assign code      = legal ? IN_CHAR[7:0] : 8'h00;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_d   = state_q;
        held_d    = held_q;
        in_num_d  = in_num_q;
        disp      = 1'b0;
        ch        = held_q;
        push      = 1'b0;
        push_data = held_q;
        pop       = 1'b0;
        clr_stack = 1'b0;
        load      = 1'b0;
        load_eq   = 1'b0;
        load_data = 8'h00;

        case (state_q)
            S_IN: if (accept) begin
                held_d = code;
                ch     = code;
                if (code >= "0" && code <= "9") begin
                    load      = 1'b1;
                    load_data = code;
                    in_num_d  = 1'b1;
                end else if (in_num_q && EMIT_SEP) begin
                    // Separator goes out first; the latched character is handled next cycle.
                    load      = 1'b1;
                    load_data = SEP_CHAR;
                    in_num_d  = 1'b0;
                    state_d   = S_DISP;
                end else begin
                    in_num_d = 1'b0;
                    disp     = 1'b1;
                end
            end
            S_DISP: disp = 1'b1;
            S_POP: begin
                if (!stk_empty && prec(top) >= prec(held_q)) begin
                    if (out_free) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        load_data = top;
                    end
                end else if (stk_full) begin
                    state_d = S_ERR;
                end else begin
                    push    = 1'b1;
                    state_d = S_IN;
                end
            end
            S_CLOSE: begin
                if (stk_empty) begin
                    state_d = S_ERR;
                end else if (top == "(") begin
                    pop     = 1'b1;
                    state_d = S_IN;
                end else if (out_free) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    load_data = top;
                end
            end
            S_FLUSH: begin
                if (stk_empty) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_eq   = 1'b1;
                        load_data = "=";
                        state_d   = S_IN;
                    end
                end else if (top == "(") begin
                    state_d = S_ERR;
                end else if (out_free) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    load_data = top;
                end
            end
            S_ERR: if (accept && code == "=") begin
                clr_stack = 1'b1;
                in_num_d  = 1'b0;
                state_d   = S_IN;
            end
            default: state_d = S_IN;
        endcase

        if (disp) begin
            state_d = S_IN;
            if (ch == "(") begin
                if (stk_full) begin
                    state_d = S_ERR;
                end else begin
                    push      = 1'b1;
                    push_data = ch;
                end
            end else if (is_op(ch)) begin
                held_d  = ch;
                state_d = S_POP;
            end else if (ch == ")") begin
                state_d = S_CLOSE;
            end else if (ch == "=") begin
                state_d = S_FLUSH;
            end else begin
                state_d = S_ERR;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IN;
            sp_q       <= '0;
            held_q     <= 8'h00;
            in_num_q   <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            out_stb_q  <= 1'b0;
            out_eq_q   <= 1'b0;
            out_char_q <= '0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            in_num_q <= in_num_d;
            err_q    <= (state_d == S_ERR);
            done_q   <= out_stb_q && OUT_ACK && out_eq_q;
            if (clr_stack)  sp_q <= '0;
            else if (push)  sp_q <= sp_q + LW'(1);
            else if (pop)   sp_q <= sp_m1;
            if (load) begin
                out_stb_q  <= 1'b1;
                out_char_q <= DATA_W'(load_data);
                out_eq_q   <= load_eq;
            end else if (OUT_ACK) begin
                out_stb_q <= 1'b0;
            end
        end
    end

    // NOTE: stack storage has no reset; the stack pointer alone defines which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) stack_mem[sp_q[IW-1:0]] <= push_data;
    end

    assign OUT_STB  = out_stb_q;
    assign OUT_CHAR = out_char_q;
    assign ERR      = err_q;
    assign DONE     = done_q;
    assign STK_LVL  = sp_q;

endmodule

// File: tb/tb_rpn_converter.sv
// Scoreboard bench for rpn_converter: expected output characters are queued per
// expression and compared as the consumer takes each character.
module tb_rpn_converter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       IN_STB = 1'b0;
    logic [7:0] IN_CHAR = 8'h00;
    logic       OUT_ACK = 1'b0;
    logic       IN_RDY, OUT_STB, ERR, DONE;
    logic [7:0] OUT_CHAR;
    logic [1:0] STK_LVL;

    rpn_converter #(
        .DATA_W(8), .STACK_DEPTH(2), .EMIT_SEP(1'b1), .SEP_CHAR(8'h20)
    ) dut (
        .CLK(CLK), .RST(RST), .IN_STB(IN_STB), .IN_CHAR(IN_CHAR), .IN_RDY(IN_RDY),
        .OUT_STB(OUT_STB), .OUT_CHAR(OUT_CHAR), .OUT_ACK(OUT_ACK),
        .ERR(ERR), .DONE(DONE), .STK_LVL(STK_LVL)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         bp_cnt = 0;
    bit         bp_mode = 1'b0;
    bit         ack_force = 1'b1;
    bit         held_v = 1'b0;
    logic [7:0] held_c;
    logic [7:0] exp_c;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer: OUT_ACK either follows ack_force or holds each character for 5 cycles.
    initial forever begin
        @(negedge CLK);
        if (!bp_mode) begin
            OUT_ACK = ack_force;
        end else if (OUT_STB) begin
            if (bp_cnt == 5) begin
                OUT_ACK = 1'b1;
                bp_cnt  = 0;
            end else begin
                OUT_ACK = 1'b0;
                bp_cnt++;
            end
        end else begin
            OUT_ACK = 1'b0;
            bp_cnt  = 0;
        end
    end

    // Monitor: sampled mid-cycle, after all inputs have settled for the next edge.
    initial forever begin
        @(negedge CLK);
        #2;
        if (RST) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_stb", OUT_STB, 1);
                check("hold_char", OUT_CHAR, held_c);
            end
            if (OUT_STB && OUT_ACK) begin
                if (sb.size() == 0) begin
                    check("extra_out", sb.size(), 1);
                end else begin
                    exp_c = sb.pop_front();
                    check("out_char", OUT_CHAR, exp_c);
                end
                held_v = 1'b0;
            end else if (OUT_STB) begin
                check("rdy_busy", IN_RDY, 0);
                held_v = 1'b1;
                held_c = OUT_CHAR;
            end else begin
                held_v = 1'b0;
            end
            if (DONE) done_cnt++;
        end
    end

    task automatic send(input logic [7:0] c);
        bit got = 1'b0;
        @(negedge CLK);
        IN_STB  = 1'b1;
        IN_CHAR = c;
        #1;
        for (int i = 0; i < 200; i++) begin
            if (IN_RDY) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
            #1;
        end
        if (got) @(posedge CLK);
        else check("rdy_timeout", IN_RDY, 1);
        #1 IN_STB = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) check("drain", sb.size(), 0);
        repeat (4) @(negedge CLK);
        #3;
    endtask

    task automatic expr(input string in_s, input string out_s, input string tag);
        int d0 = done_cnt;
        expect_str(out_s);
        send_str(in_s);
        drain();
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_err"}, ERR, 0);
        check({tag, "_lvl"}, STK_LVL, 0);
    endtask

    initial begin
        int d0;
        #1 RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #3;
        check("rst_stb", OUT_STB, 0);
        check("rst_char", OUT_CHAR, 0);
        check("rst_err", ERR, 0);
        check("rst_done", DONE, 0);
        check("rst_lvl", STK_LVL, 0);
        check("rst_rdy", IN_RDY, 1);

        expr("1+2*3=", "1 2 3 *+=", "prec");
        expr("(1+2)*3=", "1 2 +3 *=", "paren");
        expr("12-3-4=", "12 3 -4 -=", "assoc");

        // Overflow on the third '(' with a two-entry stack, then recovery.
        send_str("((");
        drain();
        check("ovf_lvl2", STK_LVL, 2);
        check("ovf_err0", ERR, 0);
        send("(");
        drain();
        check("ovf_err1", ERR, 1);
        check("ovf_lvl", STK_LVL, 2);
        d0 = done_cnt;
        send_str("5=");
        drain();
        check("ovf_clr", ERR, 0);
        check("ovf_clr_lvl", STK_LVL, 0);
        check("ovf_no_done", done_cnt - d0, 0);
        expr("7=", "7 =", "after_ovf");

        // Unbalanced ')' and unterminated '(' plus an illegal code.
        expect_str("1 ");
        send_str("1)");
        drain();
        check("close_err", ERR, 1);
        d0 = done_cnt;
        send("=");
        drain();
        check("close_clr", ERR, 0);
        check("close_no_done", done_cnt - d0, 0);
        expect_str("1 ");
        send_str("(1=");
        drain();
        check("open_err", ERR, 1);
        check("open_lvl", STK_LVL, 1);
        send("=");
        drain();
        check("open_clr", ERR, 0);
        check("open_clr_lvl", STK_LVL, 0);
        send("#");
        drain();
        check("illegal_err", ERR, 1);
        send("=");
        drain();
        check("illegal_clr", ERR, 0);

        // Backpressure: each output held for 5 cycles.
        bp_mode = 1'b1;
        expr("9=", "9 =", "bp");
        bp_mode = 1'b0;
        expr("8/2=", "8 2 /=", "div");

        // Reset mid-expression with a character stuck in the output register.
        expect_str("1 ");
        send_str("(1+");
        drain();
        check("mid_lvl", STK_LVL, 2);
        ack_force = 1'b0;
        send("2");
        repeat (2) @(negedge CLK);
        #3;
        check("mid_stb", OUT_STB, 1);
        check("mid_char", OUT_CHAR, "2");
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("mrst_stb", OUT_STB, 0);
        check("mrst_char", OUT_CHAR, 0);
        check("mrst_err", ERR, 0);
        check("mrst_done", DONE, 0);
        check("mrst_lvl", STK_LVL, 0);
        check("mrst_rdy", IN_RDY, 1);
        @(negedge CLK);
        RST = 1'b0;
        ack_force = 1'b1;
        expr("3=", "3 =", "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
